// File: rtl/ysyx_22050854_booth_mul_pipe_ctrl.sv
// Radix-4 Booth iterative multiplier for the EXU MUL path.
// Full XLEN x XLEN products (ss/su/us/uu) and a signed half-width W mode.
// Result leaves through a valid/ready handshake and is held under backpressure.
// A flush aborts any operation and drops a pending result.
// Optional build macro: BOOTH_EARLY_TERM_EN. When it is defined, CALC ends early
// once every remaining partial product is known to be zero. The results do not change.
module ysyx_22050854_booth_mul_pipe_ctrl #(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned ACC_W = 2 * XLEN + 4
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            mul_valid,
  output logic            mul_ready,
  input  logic            flush,
  input  logic            mulw,
  input  logic [1:0]      mul_signed,
  input  logic [XLEN-1:0] multiplicand,
  input  logic [XLEN-1:0] multiplier,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result_hi,
  output logic [XLEN-1:0] result_lo,
  output logic            mul_doing
);

  // Y register: XLEN+2 extended bits plus the y[-1] guard in bit 0
  localparam int unsigned YW    = XLEN + 3;
  localparam int unsigned HALF  = XLEN / 2;
  localparam int unsigned NFULL = XLEN / 2 + 1;
  localparam int unsigned NW    = XLEN / 4;
  localparam int unsigned CW    = $clog2(NFULL + 1);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StCalc = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [ACC_W-1:0] x_q;
  logic [YW-1:0]    y_q;
  logic [ACC_W-1:0] acc_q;
  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    last_q;
  logic             mulw_q;

  logic             accept;
  logic             last_pp;
  logic             early_done;
  logic [ACC_W-1:0] x_ext;
  logic [YW-1:0]    y_ext;
  logic [ACC_W-1:0] pp;
  logic [ACC_W-1:0] x_neg;
  logic             x_sign;
  logic             y_sign;
  logic             unused_acc;

  assign mul_ready = (state_q == StIdle);
  assign mul_doing = (state_q == StCalc);
  assign out_valid = (state_q == StDone);
  assign accept    = mul_valid & mul_ready & ~flush;
  assign last_pp   = (cnt_q == last_q);

`ifdef BOOTH_EARLY_TERM_EN
  // All-zero or all-one remaining Y (with guard) decodes to zero partial products only
  assign early_done = (&y_q) | (~|y_q);
`else
  assign early_done = 1'b0;
`endif

  // Operand extension for the selected mode
  always_comb begin
    x_sign = mul_signed[1] & multiplicand[XLEN-1];
    y_sign = mul_signed[0] & multiplier[XLEN-1];
    if (mulw) begin
      x_ext = {{(ACC_W - HALF){multiplicand[HALF-1]}}, multiplicand[HALF-1:0]};
      y_ext = {{(YW - HALF - 1){multiplier[HALF-1]}}, multiplier[HALF-1:0], 1'b0};
    end else begin
      x_ext = {{(ACC_W - XLEN){x_sign}}, multiplicand};
      y_ext = {{2{y_sign}}, multiplier, 1'b0};
    end
  end

  // Booth radix-4 partial product select from the low Y triplet
  always_comb begin
    x_neg = ~x_q + {{(ACC_W - 1){1'b0}}, 1'b1};
    pp    = '0;
    case (y_q[2:0])
      3'b001, 3'b010: pp = x_q;
      3'b011:         pp = {x_q[ACC_W-2:0], 1'b0};
      3'b100:         pp = {x_neg[ACC_W-2:0], 1'b0};
      3'b101, 3'b110: pp = x_neg;
      default:        pp = '0;
    endcase
  end

  // Next-state logic; flush overrides every other transition
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: if (accept) state_d = StCalc;
      StCalc: if (early_done || last_pp) state_d = StDone;
      StDone: if (out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (flush) state_d = StIdle;
  end

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath: load on accept, one Booth step per CALC cycle
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      x_q    <= '0;
      y_q    <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
      last_q <= '0;
      mulw_q <= 1'b0;
    end else if (accept) begin
      x_q    <= x_ext;
      y_q    <= y_ext;
      acc_q  <= '0;
      cnt_q  <= '0;
      last_q <= mulw ? CW'(NW - 1) : CW'(NFULL - 1);
      mulw_q <= mulw;
    end else if ((state_q == StCalc) && !flush && !early_done) begin
      acc_q <= acc_q + pp;
      x_q   <= {x_q[ACC_W-3:0], 2'b00};
      y_q   <= {{2{y_q[YW-1]}}, y_q[YW-1:2]};
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Results are forced to zero outside DONE; acc is frozen while in DONE
  always_comb begin
    result_hi = '0;
    result_lo = '0;
    if (out_valid) begin
      if (mulw_q) begin
        result_lo = {{(XLEN - HALF){acc_q[HALF-1]}}, acc_q[HALF-1:0]};
      end else begin
        result_hi = acc_q[2*XLEN-1:XLEN];
        result_lo = acc_q[XLEN-1:0];
      end
    end
  end

  // Guard bits above the 2*XLEN product are only headroom
  assign unused_acc = ^acc_q[ACC_W-1:2*XLEN];

endmodule
